tcu_drl_lane_gate: RTL and testbench
====================================

Name: tcu_drl_lane_gate

Overview:
- Stage directly downstream of the TCU DRL lane-mask generator, in the tensor-core dot-reduction datapath.
- Takes one TCK-lane operand pair, the per-lane `lane_mask` and `fmt_s`, and zeroes the masked-off lanes before the multiplier/adder tree.
- Also computes the active-lane count and a skip flag, and decouples upstream from downstream through a 2-entry elastic buffer with valid/ready handshakes.
- Keeps a saturating performance counter of masked lanes.

Parameters:
- N, 2, dot-product half width; must match the lane-mask generator's N.
- TCK, 2*N, number of lanes.
- LW, 32, bits per operand lane.
- CNTW, 32, perf counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream transaction valid
- in_ready  out  1  stage can accept
- in_a  in  TCK*LW  A operand lanes, lane i at [i*LW +: LW]
- in_b  in  TCK*LW  B operand lanes
- in_mask  in  TCK  lane_mask from the lane-mask generator
- in_fmt  in  4  format id (fmt_s)
- out_valid  out  1  transaction available
- out_ready  in  1  downstream accepts
- out_a  out  TCK*LW  gated A lanes
- out_b  out  TCK*LW  gated B lanes
- out_fmt  out  4  format id, passed through
- out_cnt  out  $clog2(TCK+1)  popcount of the lane mask
- out_skip  out  1  all lanes masked
- perf_clr  in  1  synchronous clear of perf counter
- perf_masked  out  CNTW  masked-lane count

Behaviour:
- Reset (reset_n low, asynchronous):
  - buffer empty; out_valid=0; out_* data=0; in_ready=0; perf_masked=0.
  - in_ready rises on the first clk edge after reset_n deasserts.
- Gating (combinational, before the buffer):
  - lane i: a_g[i] = in_mask[i] ? in_a[i] : 0; same for B.
  - cnt = popcount(in_mask).
  - skip = (in_mask == 0). An unsupported fmt already yields mask 0 upstream, so it propagates as skip.
- Buffer:
  - 2 entries, FIFO order preserved.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - Latency: accept at edge k gives out_valid=1 after edge k (registered, 1 cycle) when the buffer is empty.
  - in_ready is a registered flop = !(full after this edge). With 2 entries and 1 in flight, full throughput is sustained with no bubble.
  - When full: in_ready=0 and in_valid is ignored. A pop while full raises in_ready the next cycle; no same-cycle push into the freed slot.
  - Simultaneous push and pop with one entry held: occupancy stays 1, the new entry becomes head next cycle.
  - Outputs stable while out_valid & !out_ready; never retract out_valid without a pop.
  - When empty, out_* data hold their last value; only out_valid is meaningful.
- Perf counter:
  - On each pop: perf_masked += TCK - out_cnt, saturating at 2^CNTW-1.
  - perf_clr has priority over increment in the same cycle.
- Reset mid-operation: buffered entries are dropped; no pop is reported.

Decomposition:
- Package VX_tcu_pkg holds TCU_MAX_INPUTS and the TCU_*_ID format constants. Add TCU_LANE_CNTW = $clog2(TCK+1) as a function/localparam helper there.
- Buffer payload struct {a, b, fmt, cnt, skip} is a local typedef.
- One natural sub-module: tcu_drl_skid2, a generic 2-entry registered-ready elastic buffer (payload width parameter, clk/reset_n). Gating and popcount stay inline.

Test Plan:
- Reset, then single push with TCK=4, in_mask=4'b0101, in_a lanes {1,2,3,4} (lane0=1), fmt=FP32 -> next cycle out_valid=1, out_a lanes {1,0,3,0}, out_cnt=2, out_skip=0.
- in_mask=0 push -> out_skip=1, out_cnt=0, out_a=out_b=0; after pop perf_masked increments by 4.
- out_ready=0 with 3 back-to-back pushes -> 2 accepted, in_ready=0 from the cycle after the 2nd accept. Release out_ready -> outputs in order; 3rd accepted one cycle after the first pop.
- Continuous in_valid=out_ready=1 for 100 cycles -> 100 transfers, one per cycle after 1-cycle fill; data matches the gated golden model.
- perf_masked preloaded near max (force 2^32-2) then pop with cnt=0 -> saturates at 2^32-1. Assert perf_clr together with a pop -> 0.
- Assert reset_n low while 2 entries are held -> out_valid=0 and in_ready=0 immediately (async). After release, in_ready=1 one edge later, no stale output.

Source files
------------

// File: rtl/VX_tcu_pkg.sv
// ---------------------------------------------------------------------------
// VX_tcu_pkg : shared TCU constants (format ids, lane-count helper). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package VX_tcu_pkg;

   localparam int TCU_MAX_INPUTS = 32;

   localparam logic [3:0] TCU_FP32_ID = 4'd0;
   localparam logic [3:0] TCU_FP16_ID = 4'd1;
   localparam logic [3:0] TCU_BF16_ID = 4'd2;
   localparam logic [3:0] TCU_I32_ID  = 4'd8;
   localparam logic [3:0] TCU_I8_ID   = 4'd9;
   localparam logic [3:0] TCU_U8_ID   = 4'd10;
   localparam logic [3:0] TCU_I4_ID   = 4'd11;
   localparam logic [3:0] TCU_U4_ID   = 4'd12;

   // Bits needed to hold an active-lane count in 0..tck inclusive.
   function automatic int tcu_lane_cntw(input int tck);
      return $clog2(tck + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/tcu_drl_skid2.sv
// ---------------------------------------------------------------------------
// tcu_drl_skid2 : 2-entry elastic buffer with registered in_ready. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tcu_drl_skid2 #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic [1:0]    r_count;
   logic [1:0]    w_count_nxt;
   logic [DW-1:0] r_head;
   logic [DW-1:0] r_tail;
   logic          r_ready;
   logic          w_push;
   logic          w_pop;

   assign w_push    = in_valid & r_ready;
   assign w_pop     = out_valid & out_ready;
   assign out_valid = (r_count != 2'd0);
   assign in_ready  = r_ready;
   assign out_data  = r_head;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 2'd1;
         2'b01:   w_count_nxt = r_count - 2'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Head is the output register; it only moves on a push into an empty
   // slot or a pop, so data holds its last value once the buffer drains.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= 2'd0;
         r_ready <= 1'b0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt != 2'd2);
         if (w_push && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)))
            r_head <= in_data;
         else if (w_pop && (r_count == 2'd2))
            r_head <= r_tail;
         if (w_push && (r_count == 2'd1) && !w_pop)
            r_tail <= in_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/tcu_drl_lane_gate.sv
// ---------------------------------------------------------------------------
// tcu_drl_lane_gate : zero masked lanes, count active lanes, buffer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tcu_drl_lane_gate
   import VX_tcu_pkg::*;
#(
   parameter int N    = 2,
   parameter int TCK  = 2 * N,
   parameter int LW   = 32,
   parameter int CNTW = 32
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [TCK*LW-1:0]              in_a,
   input  logic [TCK*LW-1:0]              in_b,
   input  logic [TCK-1:0]                 in_mask,
   input  logic [3:0]                     in_fmt,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [TCK*LW-1:0]              out_a,
   output logic [TCK*LW-1:0]              out_b,
   output logic [3:0]                     out_fmt,
   output logic [tcu_lane_cntw(TCK)-1:0]  out_cnt,
   output logic                           out_skip,
   input  logic                           perf_clr,
   output logic [CNTW-1:0]                perf_masked
);

   localparam int CW = tcu_lane_cntw(TCK);

   typedef struct packed {
      logic [TCK*LW-1:0] a;
      logic [TCK*LW-1:0] b;
      logic [3:0]        fmt;
      logic [CW-1:0]     cnt;
      logic              skip;
   } lane_pl_t;

   lane_pl_t        w_in_pl;
   lane_pl_t        w_out_pl;
   logic            w_pop;
   logic [CNTW:0]   w_perf_sum;
   logic [CNTW-1:0] r_perf;

   always_comb begin
      w_in_pl = '0;
      for (int i = 0; i < TCK; i++) begin
         if (in_mask[i]) begin
            w_in_pl.a[i*LW +: LW] = in_a[i*LW +: LW];
            w_in_pl.b[i*LW +: LW] = in_b[i*LW +: LW];
         end
         w_in_pl.cnt = w_in_pl.cnt + CW'(in_mask[i]);
      end
      w_in_pl.fmt  = in_fmt;
      w_in_pl.skip = (in_mask == '0);
   end

   tcu_drl_skid2 #(
      .DW ($bits(lane_pl_t))
   ) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (w_in_pl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (w_out_pl)
   );

   assign out_a    = w_out_pl.a;
   assign out_b    = w_out_pl.b;
   assign out_fmt  = w_out_pl.fmt;
   assign out_cnt  = w_out_pl.cnt;
   assign out_skip = w_out_pl.skip;

   assign w_pop      = out_valid & out_ready;
   // One extra bit catches the carry that signals saturation.
   assign w_perf_sum = {1'b0, r_perf} + (CNTW+1)'(TCK - int'(w_out_pl.cnt));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_perf <= '0;
      else if (perf_clr)
         r_perf <= '0;
      else if (w_pop)
         r_perf <= w_perf_sum[CNTW] ? {CNTW{1'b1}} : w_perf_sum[CNTW-1:0];
   end

   assign perf_masked = r_perf;

endmodule

`default_nettype wire

// File: tb/tb_tcu_drl_lane_gate.sv
// ---------------------------------------------------------------------------
// tb_tcu_drl_lane_gate : directed self-checking bench for the lane gate. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tcu_drl_lane_gate;
   import VX_tcu_pkg::*;

   localparam int TCK = 4;
   localparam int LW  = 32;
   localparam int CW  = 3;
   localparam int DW  = TCK * LW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          in_valid, in_ready, out_valid, out_ready, out_skip, perf_clr;
   logic [DW-1:0] in_a, in_b, out_a, out_b;
   logic [TCK-1:0] in_mask;
   logic [3:0]    in_fmt, out_fmt;
   logic [CW-1:0] out_cnt;
   logic [31:0]   perf_masked;

   logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_skip, s_perf_clr;
   logic [DW-1:0] s_in_a, s_in_b, s_out_a, s_out_b;
   logic [TCK-1:0] s_in_mask;
   logic [3:0]    s_in_fmt, s_out_fmt;
   logic [CW-1:0] s_out_cnt;
   logic [2:0]    s_perf_masked;

   tcu_drl_lane_gate #(.N(2), .TCK(TCK), .LW(LW), .CNTW(32)) u_dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_fmt(in_fmt),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .out_fmt(out_fmt), .out_cnt(out_cnt), .out_skip(out_skip),
      .perf_clr(perf_clr), .perf_masked(perf_masked)
   );

   // Narrow counter instance so saturation is reachable in a few pops.
   tcu_drl_lane_gate #(.N(2), .TCK(TCK), .LW(LW), .CNTW(3)) u_dut_sat (
      .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_a(s_in_a), .in_b(s_in_b), .in_mask(s_in_mask), .in_fmt(s_in_fmt),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_a(s_out_a), .out_b(s_out_b),
      .out_fmt(s_out_fmt), .out_cnt(s_out_cnt), .out_skip(s_out_skip),
      .perf_clr(s_perf_clr), .perf_masked(s_perf_masked)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [3:0]    fmt;
      logic [CW-1:0] cnt;
      logic          skip;
   } exp_t;

   function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [TCK-1:0] m, input logic [3:0] f);
      exp_t e;
      e.a = '0; e.b = '0; e.cnt = '0;
      for (int i = 0; i < TCK; i++) begin
         if (m[i]) begin
            e.a[i*LW +: LW] = a[i*LW +: LW];
            e.b[i*LW +: LW] = b[i*LW +: LW];
            e.cnt = e.cnt + 3'd1;
         end
      end
      e.fmt  = f;
      e.skip = (m == '0);
      return e;
   endfunction

   exp_t   q[$];
   longint exp_perf;
   int     xfers;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Scoreboarded cycle: predicts push/pop from the handshake seen before the edge.
   task automatic step();
      exp_t e;
      bit   acc, pop;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      e   = model(in_a, in_b, in_mask, in_fmt);
      tick();
      if (pop) begin
         if (q.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            exp_perf += TCK - int'(q[0].cnt);
            void'(q.pop_front());
            xfers++;
         end
      end
      if (acc) q.push_back(e);
      if (out_valid) begin
         if (q.size() == 0) chk("sb_unexpected_valid", 1, 0);
         else begin
            chk("stream_a", out_a, q[0].a);
            chk("stream_b", out_b, q[0].b);
            chk("stream_cnt", out_cnt, q[0].cnt);
            chk("stream_skip", out_skip, q[0].skip);
            chk("stream_fmt", out_fmt, q[0].fmt);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; perf_clr = 1'b0;
      in_a = '0; in_b = '0; in_mask = '0; in_fmt = '0;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_perf_clr = 1'b0;
      s_in_a = {4{32'hDEAD_BEEF}}; s_in_b = '0; s_in_mask = '0; s_in_fmt = TCU_FP32_ID;

      // Reset state
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_a", out_a, 0);
      chk("rst_perf", perf_masked, 0);
      @(posedge clk); #3;
      reset_n = 1'b1;
      #1 chk("rel_ready_pre_edge", in_ready, 0);
      tick();
      chk("rel_ready_post_edge", in_ready, 1);

      // Single push, mask 0101
      in_valid = 1'b1; in_mask = 4'b0101; in_fmt = TCU_FP32_ID;
      in_a = {32'd4, 32'd3, 32'd2, 32'd1};
      in_b = {32'd8, 32'd7, 32'd6, 32'd5};
      tick();
      in_valid = 1'b0;
      chk("p1_valid", out_valid, 1);
      chk("p1_a", out_a, {32'd0, 32'd3, 32'd0, 32'd1});
      chk("p1_b", out_b, {32'd0, 32'd7, 32'd0, 32'd5});
      chk("p1_cnt", out_cnt, 2);
      chk("p1_skip", out_skip, 0);
      chk("p1_fmt", out_fmt, TCU_FP32_ID);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("p1_drained", out_valid, 0);
      chk("p1_perf", perf_masked, 2);

      // All-masked push propagates as skip
      in_valid = 1'b1; in_mask = 4'b0000; in_fmt = 4'hF;
      in_a = {4{32'hAAAA_5555}}; in_b = {4{32'h1234_5678}};
      tick();
      in_valid = 1'b0;
      chk("p2_skip", out_skip, 1);
      chk("p2_cnt", out_cnt, 0);
      chk("p2_a", out_a, 0);
      chk("p2_b", out_b, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("p2_perf", perf_masked, 6);
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      chk("clr_perf", perf_masked, 0);

      // Backpressure: three pushes, two fit
      in_valid = 1'b1; in_fmt = TCU_FP16_ID;
      in_mask = 4'b1111; in_a = {32'h14, 32'h13, 32'h12, 32'h11};
      tick();
      chk("bp_ready_after1", in_ready, 1);
      chk("bp_head1", out_a, {32'h14, 32'h13, 32'h12, 32'h11});
      in_mask = 4'b0011; in_a = {32'h24, 32'h23, 32'h22, 32'h21};
      tick();
      chk("bp_ready_full", in_ready, 0);
      in_mask = 4'b1000; in_a = {32'h34, 32'h33, 32'h32, 32'h31};
      tick();
      chk("bp_ready_held", in_ready, 0);
      chk("bp_head_stable", out_a, {32'h14, 32'h13, 32'h12, 32'h11});
      chk("bp_valid_held", out_valid, 1);
      out_ready = 1'b1;
      tick();
      chk("bp_ready_after_pop", in_ready, 1);
      chk("bp_head2", out_a, {32'h0, 32'h0, 32'h22, 32'h21});
      chk("bp_cnt2", out_cnt, 2);
      tick();
      in_valid = 1'b0;
      chk("bp_head3", out_a, {32'h34, 32'h0, 32'h0, 32'h0});
      chk("bp_cnt3", out_cnt, 1);
      tick();
      out_ready = 1'b0;
      chk("bp_empty", out_valid, 0);
      chk("bp_perf", perf_masked, 5);

      // Streaming at full rate against the golden model
      exp_perf = 5; xfers = 0; out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         in_a = {$urandom, $urandom, $urandom, $urandom};
         in_b = {$urandom, $urandom, $urandom, $urandom};
         in_mask = 4'($urandom_range(0, 15));
         in_fmt = 4'($urandom_range(0, 12));
         step();
         chk("stream_ready", in_ready, 1);
      end
      in_valid = 1'b0;
      step();
      chk("stream_xfers", xfers, 100);
      chk("stream_q_empty", q.size(), 0);
      chk("stream_perf", perf_masked, exp_perf[31:0]);
      out_ready = 1'b0;

      // Saturation and clear-over-increment on the narrow counter
      s_in_valid = 1'b1; s_out_ready = 1'b1;
      tick();
      chk("sat_perf0", s_perf_masked, 0);
      tick();
      chk("sat_perf4", s_perf_masked, 4);
      tick();
      chk("sat_perf_sat", s_perf_masked, 7);
      tick();
      chk("sat_perf_hold", s_perf_masked, 7);
      s_perf_clr = 1'b1;
      tick();
      chk("sat_clr_pri", s_perf_masked, 0);
      s_perf_clr = 1'b0; s_in_valid = 1'b0;
      tick();
      chk("sat_after_clr", s_perf_masked, 4);
      chk("sat_drained", s_out_valid, 0);

      // Asynchronous reset with two entries held
      in_valid = 1'b1; in_mask = 4'b1111; in_a = {4{32'h77}};
      tick();
      tick();
      in_valid = 1'b0;
      chk("mr_full_ready", in_ready, 0);
      chk("mr_full_valid", out_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mr_async_valid", out_valid, 0);
      chk("mr_async_ready", in_ready, 0);
      chk("mr_async_a", out_a, 0);
      chk("mr_async_perf", perf_masked, 0);
      @(posedge clk); #3;
      reset_n = 1'b1;
      out_ready = 1'b1;
      #1 chk("mr_rel_ready_pre", in_ready, 0);
      tick();
      chk("mr_rel_ready", in_ready, 1);
      chk("mr_rel_valid", out_valid, 0);
      tick();
      chk("mr_no_stale", out_valid, 0);
      chk("mr_perf_zero", perf_masked, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
